// File: rtl/multicycle_sequencer_if.sv
// Bundle between the multicycle sequencer and its core/memory environment.
// The sequencer is the master: it drives requests, strobes and status and samples the rest.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  // Handshake: imem_req/dmem_req stay high for every cycle of FETCH/MEM.
  // The access completes in the first cycle where req and the matching ready are both 1.
  // Ready while no request is pending is ignored.
  logic             start;
  logic [5:0]       opcode;
  logic             br_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_write;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, opcode, br_taken, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, dmem_req, dmem_we, rf_write,
           busy, halted, illegal, timeout, state, instr_count
  );

  modport slave (
    output start, opcode, br_taken, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, dmem_req, dmem_we, rf_write,
           busy, halted, illegal, timeout, state, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the KGP-RISC core: FETCH/DECODE/EXEC/MEM/WB with
// ready-handshaked memories, a wait timeout, halt detection and a retired count.
module multicycle_sequencer #(
  parameter int         CNT_W       = 16,
  parameter int         TO_W        = 8,
  parameter int         MEM_TIMEOUT = 100,
  parameter logic [5:0] HALT_OP     = 6'b111111
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q, timeout_q;

  logic is_alu, is_br, is_ld, is_st, is_halt, is_illegal;
  logic wait_hit;
  logic retire, set_illegal, set_timeout;
  logic imem_req_c, ir_write_c, pc_write_c, dmem_req_c, dmem_we_c, rf_write_c;

  // Instruction class, decoded from opcode every cycle; HALT_OP wins over any class.
  always_comb begin
    is_alu = 1'b0;
    is_br  = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    case (bus.opcode)
      6'b000001, 6'b000010, 6'b000011: is_alu = 1'b1;
      6'b100100, 6'b100101:            is_alu = 1'b1;
      6'b000100, 6'b000101, 6'b000110: is_br  = 1'b1;
      6'b100011:                       is_ld  = 1'b1;
      6'b101011:                       is_st  = 1'b1;
      default: ;
    endcase
    is_halt    = (bus.opcode == HALT_OP);
    is_illegal = !(is_halt || is_alu || is_br || is_ld || is_st);
  end

  // A ready arriving in the limit cycle still completes the access.
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_W'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    rf_write_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_illegal) begin
          set_illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          pc_write_c = bus.br_taken;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_st;
        if (bus.dmem_ready) begin
          if (is_st) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_write_c = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire)      cnt_q     <= cnt_q + 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Strobes are forced low during the reset cycle itself, whatever the old state.
  assign bus.imem_req    = imem_req_c & ~rst;
  assign bus.ir_write    = ir_write_c & ~rst;
  assign bus.pc_write    = pc_write_c & ~rst;
  assign bus.dmem_req    = dmem_req_c & ~rst;
  assign bus.dmem_we     = dmem_we_c  & ~rst;
  assign bus.rf_write    = rf_write_c & ~rst;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal     = illegal_q;
  assign bus.timeout     = timeout_q;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule
